fft_stage_sequencer: RTL and testbench

Frame-level controller for the shared radix-2 FFT stage datapath (FFT_step).
- Collects SAMPLES samples from a streaming source into a frame buffer.
- Runs the buffer through the stage datapath once per stage, STAGES = log2(SAMPLES) passes, presenting the stage index each pass and capturing the results back into the buffer.
- Streams the finished frame out.
- Sits between the ADC/sample front end and the display/spectrum consumer. Exactly one frame is in flight at a time.

---
 rtl/fft_stage_sequencer.sv | 141 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - frame load / per-stage launch+capture / unload controller for a shared FFT stage datapath
// Optional: FFT_SEQ_BITREV_EN stores input sample k at frame[bitrev(k)] (decimation-in-time order).
module fft_stage_sequencer #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [SAMPLES*WIDTH-1:0]      stage_data,
  output logic [$clog2(SAMPLES)-1:0]    stage_idx,
  output logic                          stage_start,
  input  logic [SAMPLES*WIDTH-1:0]      stage_result,
  input  logic                          stage_done,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          error
);

  localparam int IW     = $clog2(SAMPLES);
  localparam int STAGES = IW;
  localparam int WDW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]    stage_idx_q, stage_idx_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] frame_q [SAMPLES];
  logic [WIDTH-1:0] frame_d [SAMPLES];
  logic [IW-1:0]    wr_addr;

`ifdef FFT_SEQ_BITREV_EN
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < IW; i++) wr_addr[i] = wr_cnt_q[IW-1-i];
  end
`else
  assign wr_addr = wr_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    stage_idx_d = stage_idx_q;
    wd_cnt_d    = wd_cnt_q;
    error_d     = error_q;
    for (int i = 0; i < SAMPLES; i++) frame_d[i] = frame_q[i];

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          frame_d[wr_addr] = in_data;
          wr_cnt_d         = wr_cnt_q + IW'(1);
          if (wr_cnt_q == IW'(SAMPLES - 1)) begin
            stage_idx_d = '0;
            state_d     = S_START;
          end
        end
      end
      S_START: begin
        wd_cnt_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (stage_done) begin
          for (int i = 0; i < SAMPLES; i++) frame_d[i] = stage_result[i*WIDTH +: WIDTH];
          if (stage_idx_q == IW'(STAGES - 1)) begin
            rd_cnt_d = '0;
            state_d  = S_UNLOAD;
          end else begin
            stage_idx_d = stage_idx_q + IW'(1);
            state_d     = S_START;
          end
        end else if (TIMEOUT > 0) begin
          // abort on the TIMEOUT-th consecutive RUN cycle without stage_done
          if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
            error_d     = 1'b1;
            state_d     = S_LOAD;
            wr_cnt_d    = '0;
            stage_idx_d = '0;
            for (int i = 0; i < SAMPLES; i++) frame_d[i] = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
          end
        end
      end
      default: begin
        if (out_ready) begin
          rd_cnt_d = rd_cnt_q + IW'(1);
          if (rd_cnt_q == IW'(SAMPLES - 1)) state_d = S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stage_idx_q <= '0;
      wd_cnt_q    <= '0;
      error_q     <= 1'b0;
      for (int i = 0; i < SAMPLES; i++) frame_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      stage_idx_q <= stage_idx_d;
      wd_cnt_q    <= wd_cnt_d;
      error_q     <= error_d;
      for (int i = 0; i < SAMPLES; i++) frame_q[i] <= frame_d[i];
    end
  end

  for (genvar g = 0; g < SAMPLES; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = frame_q[g];
  end

  assign in_ready    = (state_q == S_LOAD);
  assign stage_start = (state_q == S_START);
  assign stage_idx   = stage_idx_q;
  assign out_valid   = (state_q == S_UNLOAD);
  assign out_data    = out_valid ? frame_q[rd_cnt_q] : '0;
  assign busy        = (state_q != S_LOAD);
  assign error       = error_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for fft_stage_sequencer with a stub stage datapath
module tb_fft_stage_sequencer;

  localparam int SAMPLES = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 10;
  localparam int IW      = 2;
  localparam int STAGES  = 2;
  localparam logic [31:0] TOTAL_ADD = 32'd3;  // stage 0 adds 1, stage 1 adds 2

  logic                     clk = 1'b0;
  logic                     reset;
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [SAMPLES*WIDTH-1:0] stage_data;
  logic [IW-1:0]            stage_idx;
  logic                     stage_start;
  logic [SAMPLES*WIDTH-1:0] stage_result;
  logic                     stage_done;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     error;

  fft_stage_sequencer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stage_data(stage_data), .stage_idx(stage_idx), .stage_start(stage_start),
    .stage_result(stage_result), .stage_done(stage_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // stub datapath: result = data + idx + 1, done 3 cycles after stage_start
  logic [2:0] stub_cnt;
  logic       stub_en;
  always @(posedge clk) begin
    if (reset) stub_cnt <= 3'd0;
    else if (stage_start) stub_cnt <= 3'd3;
    else if (stub_cnt != 3'd0) stub_cnt <= stub_cnt - 3'd1;
  end
  assign stage_done = stub_en && (stub_cnt == 3'd1);
  for (genvar g = 0; g < SAMPLES; g++) begin : g_stub
    assign stage_result[g*WIDTH +: WIDTH] = stage_data[g*WIDTH +: WIDTH] + 32'(stage_idx) + 32'd1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          exp_idx = 0;
  int          n_out = 0;
  int          n_start = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int out_src(input int j);
`ifdef FFT_SEQ_BITREV_EN
    return ((j & 1) << 1) | ((j >> 1) & 1);
`else
    return j;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", out_valid, 1'b0);
        else check_eq("out_data", out_data, exp_q.pop_front());
        n_out++;
      end
      if (stage_start) begin
        check_eq("stage_idx", stage_idx, exp_idx);
        exp_idx = (exp_idx + 1) % STAGES;
        n_start++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] s3, input bit gaps, input bit push_exp);
    logic [31:0] s [4];
    int          start_base;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    if (push_exp)
      for (int j = 0; j < SAMPLES; j++) exp_q.push_back(s[out_src(j)] + TOTAL_ADD);
    start_base = n_start;
    for (int k = 0; k < SAMPLES; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        step();
      end
      for (int b = 0; b < 200 && !in_ready; b++) step();
      check_eq("in_ready_load", in_ready, 1'b1);
      if (gaps) check_eq("no_early_start", n_start, start_base);
      in_data  = s[k];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check_eq("start_latency", stage_start, 1'b1);
    check_eq("in_ready_drop", in_ready, 1'b0);
  endtask

  task automatic finish_frame();
    int b;
    for (b = 0; b < 300 && exp_q.size() != 0; b++) step();
    check_eq("frame_drained", exp_q.size(), 0);
    step();
    check_eq("busy_after_unload", busy, 1'b0);
    check_eq("out_valid_after_unload", out_valid, 1'b0);
  endtask

  initial begin
    int base;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    stub_en   = 1'b1;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_stage_start", stage_start, 1'b0);
    check_eq("rst_stage_idx", stage_idx, 0);
    check_eq("rst_stage_data", stage_data, 0);
    reset = 1'b0;
    step();

    // basic frame
    send_frame(32'd100, 32'd200, 32'd150, 32'd250, 1'b0, 1'b1);
    finish_frame();
    check_eq("basic_starts", n_start, 2);

    // backpressure at rd_cnt = 1
    base = n_out;
    send_frame(32'd100, 32'd200, 32'd150, 32'd250, 1'b0, 1'b1);
    for (int b = 0; b < 100 && n_out != base + 1; b++) step();
    check_eq("bp_first_out", n_out, base + 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid_hold", out_valid, 1'b1);
      check_eq("bp_data_hold", out_data, exp_q[0]);
      step();
    end
    check_eq("bp_no_advance", n_out, base + 1);
    out_ready = 1'b1;
    finish_frame();
    check_eq("bp_count", n_out, base + 4);

    // gapped input, then two's-complement wrap and random words
    send_frame(32'd100, 32'd200, 32'd150, 32'd250, 1'b1, 1'b1);
    finish_frame();
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, $urandom, 1'b0, 1'b1);
    finish_frame();

    // watchdog
    stub_en = 1'b0;
    send_frame(32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b0);
    n = 0;
    while (!error && n < 60) begin
      step();
      n++;
    end
    check_eq("wd_error_cycles", n, TIMEOUT + 1);
    check_eq("wd_in_ready", in_ready, 1'b1);
    check_eq("wd_busy", busy, 1'b0);
    exp_idx = 0;
    stub_en = 1'b1;
    send_frame(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1);
    finish_frame();
    check_eq("wd_error_sticky", error, 1'b1);

    // reset while RUN at stage_idx 1
    send_frame(32'd9, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0);
    for (int b = 0; b < 50 && !(stage_start && stage_idx == 2'd1); b++) step();
    check_eq("mid_run_reached", stage_idx, 1);
    step();
    reset = 1'b1;
    step();
    check_eq("mr_in_ready", in_ready, 1'b1);
    check_eq("mr_out_valid", out_valid, 1'b0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_error", error, 1'b0);
    check_eq("mr_stage_idx", stage_idx, 0);
    check_eq("mr_stage_start", stage_start, 1'b0);
    reset   = 1'b0;
    exp_idx = 0;
    base    = n_out;
    for (int c = 0; c < 12; c++) step();
    check_eq("mr_no_output", n_out, base);
    send_frame(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
